// File: rtl/plot_sched_pkg.sv
// Shared types and screen/sprite geometry defaults for the plot scheduler.
package plot_sched_pkg;
    localparam int SCR_W_DEF   = 160;
    localparam int SCR_H_DEF   = 120;
    localparam int SPR_DIM_DEF = 8;

    typedef logic [2:0] colour_t;

    typedef enum logic [2:0] {IDLE, BG, SEL, SPR, DONE} state_t;
endpackage

// File: rtl/plot_scheduler_raster_counter.sv
// Row-major x/y scan counter: x runs fastest, both wrap to 0 after the last pixel.
module raster_counter #(
    parameter int W = 8,
    parameter int H = 8,
    localparam int XW = (W > 1) ? $clog2(W) : 1,
    localparam int YW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);

    assign last = (x == XMAX) && (y == YMAX);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == XMAX) begin
                x <= '0;
                y <= (y == YMAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/plot_scheduler.sv
// Frame sequencer for the VGA write port: full background repaint, then prioritised sprite overlay.
// Build option PLOT_SCHED_TRANSP_EN: sprite pixels equal to TRANSP are not plotted.
module plot_scheduler
    import plot_sched_pkg::*;
#(
    parameter int      NSPR    = 3,
    parameter int      SCR_W   = SCR_W_DEF,
    parameter int      SCR_H   = SCR_H_DEF,
    parameter int      SPR_DIM = SPR_DIM_DEF,
    parameter colour_t TRANSP  = 3'b000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              frame_tick,
    output logic [14:0]       bg_addr,
    input  colour_t           bg_colour,
    input  logic [NSPR-1:0]   spr_req,
    input  logic [NSPR*8-1:0] spr_x,
    input  logic [NSPR*7-1:0] spr_y,
    output logic [NSPR-1:0]   spr_gnt,
    output logic [5:0]        spr_addr,
    input  colour_t           spr_colour,
    output logic [7:0]        oX,
    output logic [6:0]        oY,
    output colour_t           oColour,
    output logic              plot,
    output logic              busy,
    output logic              done
);
    localparam int BXW = $clog2(SCR_W);
    localparam int BYW = $clog2(SCR_H);
    localparam int SW  = (SPR_DIM > 1) ? $clog2(SPR_DIM) : 1;
`ifdef PLOT_SCHED_TRANSP_EN
    localparam bit TRANSP_ON = 1'b1;
`else
    localparam bit TRANSP_ON = 1'b0;
`endif

    state_t            state, state_nx;
    logic              pending;
    logic [NSPR-1:0]   served, cur_gnt;
    logic [7:0]        x0;
    logic [6:0]        y0;
    logic              plot_q, src_spr;
    logic [BXW-1:0]    bg_x;
    logic [BYW-1:0]    bg_y;
    logic              bg_last;
    logic [SW-1:0]     spr_col, spr_row;
    logic              spr_last;
    logic              pick_found;
    logic [NSPR-1:0]   pick_oh;
    logic [7:0]        pick_x;
    logic [6:0]        pick_y;
    logic [8:0]        sum_x;
    logic [7:0]        sum_y;
    logic              in_bounds;

    raster_counter #(.W(SCR_W), .H(SCR_H)) u_bg_scan (
        .Clock(Clock), .Resetn(Resetn), .en(state == BG),
        .x(bg_x), .y(bg_y), .last(bg_last)
    );

    raster_counter #(.W(SPR_DIM), .H(SPR_DIM)) u_spr_scan (
        .Clock(Clock), .Resetn(Resetn), .en(state == SPR),
        .x(spr_col), .y(spr_row), .last(spr_last)
    );

    assign bg_addr  = 15'(bg_y) * 15'(SCR_W) + 15'(bg_x);
    assign spr_addr = 6'(spr_row) * 6'(SPR_DIM) + 6'(spr_col);

    // One bit of headroom so off-screen sprite pixels clip instead of wrapping.
    assign sum_x     = {1'b0, x0} + 9'(spr_col);
    assign sum_y     = {1'b0, y0} + 8'(spr_row);
    assign in_bounds = (sum_x < 9'(SCR_W)) && (sum_y < 8'(SCR_H));

    // Descending scan so the lowest pending index wins.
    always_comb begin
        pick_found = 1'b0;
        pick_oh    = '0;
        pick_x     = '0;
        pick_y     = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (spr_req[i] && !served[i]) begin
                pick_found = 1'b1;
                pick_oh    = NSPR'(1) << i;
                pick_x     = spr_x[8*i +: 8];
                pick_y     = spr_y[7*i +: 7];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (frame_tick || pending) state_nx = BG;
            BG:   if (bg_last) state_nx = SEL;
            SEL:  state_nx = pick_found ? SPR : DONE;
            SPR:  if (spr_last) state_nx = SEL;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pending <= 1'b0;
            served  <= '0;
            cur_gnt <= '0;
            x0      <= '0;
            y0      <= '0;
            plot_q  <= 1'b0;
            src_spr <= 1'b0;
            oX      <= '0;
            oY      <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE)   pending <= 1'b0;
            else if (frame_tick) pending <= 1'b1;
            if (state == SEL && pick_found) begin
                cur_gnt <= pick_oh;
                x0      <= pick_x;
                y0      <= pick_y;
            end
            if (state == SPR && spr_last) served <= served | cur_gnt;
            else if (state == DONE)       served <= '0;
            // Write side trails the address by one cycle to meet the ROM data.
            plot_q  <= (state == BG) || (state == SPR && in_bounds);
            src_spr <= (state == SPR);
            oX      <= (state == SPR) ? sum_x[7:0] : 8'(bg_x);
            oY      <= (state == SPR) ? sum_y[6:0] : 7'(bg_y);
        end
    end

    // Grant stays up through the ROM data cycle following SPR.
    assign spr_gnt = (state == SPR || src_spr) ? cur_gnt : '0;
    assign busy    = (state != IDLE);
    assign plot    = plot_q && !(TRANSP_ON && src_spr && (spr_colour == TRANSP));
    assign oColour = plot ? (src_spr ? spr_colour : bg_colour) : 3'b000;
endmodule

// File: tb/tb_plot_scheduler.sv
// Randomised bench for plot_scheduler: ROM models plus a frame-level expected write stream.
module tb_plot_scheduler;
    logic        Clock = 1'b0;
    logic        Resetn, frame_tick;
    logic [14:0] bg_addr;
    logic [2:0]  bg_colour;
    logic [2:0]  spr_req, spr_gnt, spr_colour;
    logic [23:0] spr_x;
    logic [20:0] spr_y;
    logic [5:0]  spr_addr;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [2:0]  oColour;
    logic        plot, busy, done;

    always #5 Clock = ~Clock;

    plot_scheduler dut (
        .Clock(Clock), .Resetn(Resetn), .frame_tick(frame_tick),
        .bg_addr(bg_addr), .bg_colour(bg_colour),
        .spr_req(spr_req), .spr_x(spr_x), .spr_y(spr_y),
        .spr_gnt(spr_gnt), .spr_addr(spr_addr), .spr_colour(spr_colour),
        .oX(oX), .oY(oY), .oColour(oColour),
        .plot(plot), .busy(busy), .done(done)
    );

    int bg_mode, spr_mode, seed;

    function automatic logic [2:0] bg_fn(int a);
        if (bg_mode == 0) return 3'(a);
        return 3'((a ^ (a >> 4)) + seed);
    endfunction

    function automatic logic [2:0] spr_fn(int i, int a);
        if (spr_mode == 1) return ((((a >> 3) ^ a) & 1) != 0) ? 3'd7 : 3'd0;
        return 3'(a * 5 + i * 3 + seed);
    endfunction

    // Synchronous ROMs, one cycle of latency; grant muxes the sprite ROMs.
    logic [2:0] rom_q [3];
    always @(posedge Clock) begin
        bg_colour <= bg_fn(int'(bg_addr));
        for (int i = 0; i < 3; i++) rom_q[i] <= spr_fn(i, int'(spr_addr));
    end
    always_comb begin
        spr_colour = 3'b000;
        for (int i = 0; i < 3; i++) if (spr_gnt[i]) spr_colour = spr_colour | rom_q[i];
    end

    logic [17:0] exp_q[$];
    logic [2:0]  gseq[$];
    logic [2:0]  last_gnt;
    int cyc, tick_cyc, nplot, bad, oob, gnt_cyc, first_plot, done_cyc;
    int n_tests, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge and score plots against the model.
    task automatic step();
        logic [17:0] e;
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        if (plot) begin
            if (first_plot < 0) first_plot = cyc;
            nplot++;
            if (oX >= 8'd160 || oY >= 7'd120) oob++;
            if (exp_q.size() == 0) bad++;
            else begin
                e = exp_q.pop_front();
                if ({oX, oY, oColour} !== e) bad++;
            end
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (spr_gnt != 3'b000) begin
            gnt_cyc++;
            if (spr_gnt != last_gnt) gseq.push_back(spr_gnt);
        end
        last_gnt = spr_gnt;
    endtask

    task automatic clear_mon();
        nplot = 0; bad = 0; oob = 0; gnt_cyc = 0;
        first_plot = -1; done_cyc = -1; last_gnt = 3'b000;
        gseq.delete();
        exp_q.delete();
    endtask

    // Expected write stream: whole background in raster order, then each requested
    // sprite by ascending index with off-screen (and optionally transparent) pixels dropped.
    task automatic add_frame(input logic [2:0] req, input logic [23:0] xs, input logic [20:0] ys);
        int px, py;
        logic [2:0] c;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back({8'(x), 7'(y), bg_fn(y * 160 + x)});
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                for (int r = 0; r < 8; r++) begin
                    for (int cc = 0; cc < 8; cc++) begin
                        px = int'(xs[8*i +: 8]) + cc;
                        py = int'(ys[7*i +: 7]) + r;
                        c  = spr_fn(i, r * 8 + cc);
`ifdef PLOT_SCHED_TRANSP_EN
                        if (c == 3'b000) continue;
`endif
                        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), c});
                    end
                end
            end
        end
    endtask

    task automatic fire();
        frame_tick = 1'b1;
        tick_cyc = cyc;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cyc < 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, done_cyc >= 0, 1);
    endtask

    logic [5:0] gpack;
    int px1, py1, dref, n;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        Resetn = 1'b0; frame_tick = 1'b0;
        spr_req = '0; spr_x = '0; spr_y = '0;
        bg_mode = 0; spr_mode = 0; seed = 0;
        clear_mon();
        repeat (3) step();
        chk("reset_outs", {plot, busy, done, spr_gnt, oX, oY, oColour}, 0);
        Resetn = 1'b1;
        step();
        chk("idle_outs", {plot, busy, done, spr_gnt}, 0);

        // Background only, ROM = address low bits
        clear_mon();
        add_frame(spr_req, spr_x, spr_y);
        fire();
        chk("f1_busy_after_tick", busy, 1);
        wait_done("f1_done_seen", 25000);
        chk("f1_busy_at_done", busy, 0);
        chk("f1_first_plot_cyc", first_plot - tick_cyc, 2);
        chk("f1_done_cyc", done_cyc - tick_cyc, 19203);
        chk("f1_nplot", nplot, 19200);
        chk("f1_bad_plots", bad, 0);
        chk("f1_gnt_cycles", gnt_cyc, 0);
        chk("f1_leftover", exp_q.size(), 0);

        // Two sprites (0 and 2); sprite 0 inputs disturbed after its grant
        seed = int'($urandom); bg_mode = 1; spr_mode = 0;
        spr_req = 3'b101;
        spr_x = {8'd50, 8'($urandom), 8'd10};
        spr_y = {7'd60, 7'($urandom), 7'd20};
        clear_mon();
        add_frame(spr_req, spr_x, spr_y);
        fire();
        n = 0;
        while (spr_gnt != 3'b001 && n < 25000) begin step(); n++; end
        chk("f2_gnt0_seen", spr_gnt, 3'b001);
        repeat ($urandom_range(1, 50)) step();
        spr_req = 3'b100;
        spr_x[15:0] = 16'($urandom);
        spr_y[13:0] = 14'($urandom);
        wait_done("f2_done_seen", 1000);
        chk("f2_done_cyc", done_cyc - tick_cyc, 19333);
        chk("f2_nplot", nplot, 19328);
        chk("f2_bad_plots", bad, 0);
        chk("f2_gnt_cycles", gnt_cyc, 130);
        gpack = '0;
        foreach (gseq[k]) gpack = {gpack[2:0], gseq[k]};
        chk("f2_gnt_seq", {gseq.size(), gpack}, {32'd2, 6'b001100});
        chk("f2_leftover", exp_q.size(), 0);

        // Edge-clipped sprite + checkerboard sprite; extra ticks during BG
        seed = int'($urandom); spr_mode = 1;
        px1 = int'($urandom_range(0, 152)); py1 = int'($urandom_range(0, 112));
        spr_req = 3'b011;
        spr_x = {8'd0, 8'(px1), 8'd156};
        spr_y = {7'd0, 7'(py1), 7'd116};
        clear_mon();
        add_frame(spr_req, spr_x, spr_y);
        fire();
        repeat ($urandom_range(10, 5000)) step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        repeat (3) step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        wait_done("f3_done_seen", 25000);
        chk("f3_done_cyc", done_cyc - tick_cyc, 19333);
        chk("f3_busy_at_done", busy, 0);
`ifdef PLOT_SCHED_TRANSP_EN
        chk("f3_nplot", nplot, 19200 + 8 + 32);
`else
        chk("f3_nplot", nplot, 19200 + 16 + 64);
`endif
        chk("f3_bad_plots", bad, 0);
        chk("f3_offscreen", oob, 0);
        chk("f3_leftover", exp_q.size(), 0);

        // Pending redraw starts on its own; reset lands in a sprite
        dref = done_cyc;
        spr_req = 3'($urandom_range(1, 7));
        for (int i = 0; i < 3; i++) begin
            spr_x[8*i +: 8] = 8'($urandom_range(0, 200));
            spr_y[7*i +: 7] = 7'($urandom_range(0, 127));
        end
        clear_mon();
        add_frame(spr_req, spr_x, spr_y);
        step();
        chk("f4_busy_restart", busy, 1);
        step();
        chk("f4_first_plot_cyc", first_plot - dref, 2);
        n = 0;
        while (spr_gnt == 3'b000 && n < 25000) begin step(); n++; end
        chk("f4_gnt_seen", spr_gnt != 3'b000, 1);
        repeat ($urandom_range(1, 60)) step();
        Resetn = 1'b0;
        step();
        chk("rst_mid_spr_outs", {plot, spr_gnt, busy}, 0);
        chk("f4_bad_plots", bad, 0);
        chk("f4_offscreen", oob, 0);
        Resetn = 1'b1;
        step();

        // Fresh tick after reset restarts at pixel (0,0)
        seed = int'($urandom);
        spr_req = '0;
        clear_mon();
        add_frame(spr_req, spr_x, spr_y);
        fire();
        repeat (39) step();
        chk("f5_first_plot_cyc", first_plot - tick_cyc, 2);
        chk("f5_nplot", nplot, 39);
        chk("f5_bad_plots", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
